if_fetch_unit: RTL

- Fetch stage producer that drives the IF/ID pipeline register.
- Owns the PC and issues in-order requests to instruction memory over a valid/ready request channel and a fixed-order response channel.
- Buffers returned instructions in a small FIFO and presents one instruction plus its PC per cycle to IF/ID, honouring the stall and IFIDWrite controls.
- On a branch/jump redirect from EX, flushes buffered and in-flight wrong-path instructions.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/if_fetch_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and the FIFO entry type for the instruction fetch unit.
package fetch_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSN = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP  = 64'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, insn} entries with push, pop and a dominant flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW:0]    rd_ptr;
    logic [AW:0]    wr_ptr;
    logic           do_push;
    logic           do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests, buffers responses for IF/ID.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/drop/stall performance counters.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = 64'h0,
    parameter int              FIFO_DEPTH      = 2,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [ILEN-1:0]   imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              stall,
    input  logic              IFIDWrite,
    output logic [ILEN-1:0]   instruction,
    output logic [XLEN-1:0]   A,
    output logic              fetch_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_drop_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = ((OW > CW) ? OW : CW) + 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic              fetch_en;
    logic [XLEN-1:0]   pc;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     outstanding_next;
    logic [OW-1:0]     drop_cnt;
    logic [PW-1:0]     pcq_wr;
    logic [PW-1:0]     pcq_rd;
    logic [XLEN-1:0]   pcq [MAX_OUTSTANDING];
    logic [SW-1:0]     credit_sum;
    logic              req_fire;
    logic              rsp_keep;
    logic              consume;
    fetch_entry_t      fifo_push_data;
    fetch_entry_t      fifo_head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // fetch_en keeps the request channel idle while reset is asserted.
    assign credit_sum       = SW'(outstanding) + SW'(fifo_count);
    assign imem_req_valid   = fetch_en && !fifo_full && (credit_sum < SW'(FIFO_DEPTH))
                              && (outstanding < OW'(MAX_OUTSTANDING));
    assign imem_req_addr    = pc;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign outstanding_next = outstanding + OW'(req_fire) - OW'(imem_rsp_valid);
    assign rsp_keep         = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    assign fifo_push_data   = '{pc: pcq[pcq_rd], insn: imem_rsp_data};

    assign fetch_valid = !fifo_empty;
    assign consume     = fetch_valid && !stall && IFIDWrite;
    assign instruction = fifo_empty ? NOP_INSN : fifo_head.insn;
    assign A           = fifo_empty ? '0 : fifo_head.pc;

    // The PC queue is never flushed: it pairs every response, kept or dropped, with its address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_en    <= 1'b0;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
        end else begin
            fetch_en    <= 1'b1;
            outstanding <= outstanding_next;
            if (req_fire)       pcq_wr <= next_ptr(pcq_wr);
            if (imem_rsp_valid) pcq_rd <= next_ptr(pcq_rd);
            if (redirect_valid) begin
                pc       <= {redirect_pc[XLEN-1:2], 2'b00};
                drop_cnt <= outstanding_next;
            end else begin
                if (req_fire) pc <= pc + PC_STEP;
                if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) pcq[pcq_wr] <= pc;
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rsp_keep),
        .push_data(fifo_push_data),
        .pop      (consume && !redirect_valid),
        .flush    (redirect_valid),
        .head     (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

`ifdef FETCH_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (consume) perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
            if (imem_rsp_valid && ((drop_cnt != '0) || redirect_valid))
                perf_drop_cnt <= sat_inc(perf_drop_cnt);
            if (fetch_valid && stall) perf_stall_cnt <= sat_inc(perf_stall_cnt);
        end
    end
`endif
endmodule
